// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle: opcode/zero in, decoded controls out.
// Latency: none (wires only).
// Backpressure: none; the control unit advances every cycle.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal_op;

    modport master (
        input  opcode, zero,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state, illegal_op
    );

    modport slave (
        output opcode, zero,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, state, illegal_op
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style Moore control FSM; ADDI path enabled by MC_CTRL_ADDI_EN.
// Latency: controls registered with the state; pc_en/illegal_op add combinational zero/opcode terms.
// Backpressure: none; one state step per clock, rst forces FETCH and zeroes all outputs.
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic                        clk,
    input  logic                        rst,
    multicycle_control_if.master        bus
);
`ifdef MC_CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI = 6'h08;
`endif

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXEC     = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9
`ifdef MC_CTRL_ADDI_EN
        ,
        S_ADDIEXEC = 4'd10,
        S_ADDIWB   = 4'd11
`endif
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            S_DECODE:  c.alu_src_b = 2'b11;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_source     = 2'b01;
                c.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                c.pc_source = 2'b10;
                c.pc_write  = 1'b1;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDIWB:  c.reg_write = 1'b1;
`endif
            default:   c = '0;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    ctrl_t  ctrl_o;
    logic   op_legal;

    always_comb begin
        state_d  = S_FETCH;
        op_legal = 1'b1;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (bus.opcode == OP_LW || bus.opcode == OP_SW) state_d = S_MEMADR;
                else if (bus.opcode == OP_RTYPE)                state_d = S_EXEC;
                else if (bus.opcode == OP_BEQ)                  state_d = S_BRANCH;
                else if (bus.opcode == OP_J)                    state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                else if (bus.opcode == OP_ADDI)                 state_d = S_ADDIEXEC;
`endif
                else                                            op_legal = 1'b0;
            end
            // An opcode that changed under MEMADR falls back to FETCH with no memory access.
            S_MEMADR: begin
                if (bus.opcode == OP_LW)      state_d = S_MEMRD;
                else if (bus.opcode == OP_SW) state_d = S_MEMWR;
                else                          state_d = S_FETCH;
            end
            S_MEMRD:    state_d = S_MEMWB;
            S_EXEC:     state_d = S_ALUWB;
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEXEC: state_d = S_ADDIWB;
`endif
            default:    state_d = S_FETCH;
        endcase
        ctrl_d = decode(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ctrl_q  <= decode(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Reset gates every output combinationally so nothing leaks while rst is held.
    assign ctrl_o         = rst ? '0 : ctrl_q;
    assign bus.pc_en      = ctrl_o.pc_write | (ctrl_o.pc_write_cond & bus.zero);
    assign bus.iord       = ctrl_o.iord;
    assign bus.mem_read   = ctrl_o.mem_read;
    assign bus.mem_write  = ctrl_o.mem_write;
    assign bus.ir_write   = ctrl_o.ir_write;
    assign bus.reg_dst    = ctrl_o.reg_dst;
    assign bus.mem_to_reg = ctrl_o.mem_to_reg;
    assign bus.reg_write  = ctrl_o.reg_write;
    assign bus.alu_src_a  = ctrl_o.alu_src_a;
    assign bus.alu_src_b  = ctrl_o.alu_src_b;
    assign bus.alu_op     = ctrl_o.alu_op;
    assign bus.pc_source  = ctrl_o.pc_source;
    assign bus.state      = rst ? 4'd0 : state_q;
    assign bus.illegal_op = ~rst & (state_q == S_DECODE) & ~op_legal;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: vector table, reset corner cases, random instruction stream.
module tb_multicycle_control;
    logic clk;
    logic rst;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } out_t;

    typedef struct {
        logic [5:0] opc;
        int         z;
        int         lat;
        int         rw;
        int         mw;
        int         ill;
        int         pcen;
        int         jsrc;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cnt_rw, cnt_mw, cnt_ill, cnt_pcen, cnt_jsrc;
    int seq_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] o);
        bit l;
        l = (o == 6'h00) || (o == 6'h23) || (o == 6'h2B) || (o == 6'h04) || (o == 6'h02);
`ifdef MC_CTRL_ADDI_EN
        if (o == 6'h08) l = 1'b1;
`endif
        return l;
    endfunction

    // Steps an instruction visits after FETCH, straight from its description.
    task automatic load_seq(input logic [5:0] o);
        seq_q.delete();
        seq_q.push_back(1);
        case (o)
            6'h23: begin seq_q.push_back(2); seq_q.push_back(3); seq_q.push_back(4); end
            6'h2B: begin seq_q.push_back(2); seq_q.push_back(5); end
            6'h00: begin seq_q.push_back(6); seq_q.push_back(7); end
            6'h04: seq_q.push_back(8);
            6'h02: seq_q.push_back(9);
`ifdef MC_CTRL_ADDI_EN
            6'h08: begin seq_q.push_back(10); seq_q.push_back(11); end
`endif
            default: ;
        endcase
    endtask

    function automatic out_t exp_out(input int s, input logic [5:0] o, input logic z);
        out_t e;
        e = '0;
        case (s)
            0: begin e.mem_read = 1; e.ir_write = 1; e.alu_src_b = 2'b01; e.pc_en = 1; end
            1: begin e.alu_src_b = 2'b11; e.illegal_op = !is_legal(o); end
            2: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            3: begin e.mem_read = 1; e.iord = 1; end
            4: begin e.reg_write = 1; e.mem_to_reg = 1; end
            5: begin e.mem_write = 1; e.iord = 1; end
            6: begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            7: begin e.reg_write = 1; e.reg_dst = 1; end
            8: begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_source = 2'b01; e.pc_en = z; end
            9: begin e.pc_source = 2'b10; e.pc_en = 1; end
`ifdef MC_CTRL_ADDI_EN
            10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            11: e.reg_write = 1;
`endif
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic out_t sample();
        out_t a;
        a.pc_en      = bus.pc_en;
        a.iord       = bus.iord;
        a.mem_read   = bus.mem_read;
        a.mem_write  = bus.mem_write;
        a.ir_write   = bus.ir_write;
        a.reg_dst    = bus.reg_dst;
        a.mem_to_reg = bus.mem_to_reg;
        a.reg_write  = bus.reg_write;
        a.alu_src_a  = bus.alu_src_a;
        a.alu_src_b  = bus.alu_src_b;
        a.alu_op     = bus.alu_op;
        a.pc_source  = bus.pc_source;
        a.illegal_op = bus.illegal_op;
        return a;
    endfunction

    // One clock: drive inputs just after posedge, compare at negedge, return just after next posedge.
    task automatic one_cycle(input int exp_s, input logic [5:0] o, input int zmode);
        out_t act, exp;
        bus.opcode = (exp_s == 1 || exp_s == 2 || exp_s == 10 || exp_s == 11) ? o : 6'($urandom);
        bus.zero   = (zmode == 2) ? 1'($urandom) : 1'(zmode);
        @(negedge clk);
        act = sample();
        exp = rst ? out_t'('0) : exp_out(exp_s, bus.opcode, bus.zero);
        chk($sformatf("ctrl_s%0d", exp_s), int'(act), int'(exp));
        chk("state", int'(bus.state), rst ? 0 : exp_s);
        cnt_rw   += int'(act.reg_write);
        cnt_mw   += int'(act.mem_write);
        cnt_ill  += int'(act.illegal_op);
        cnt_pcen += int'(act.pc_en);
        cnt_jsrc += int'(act.pc_source == 2'b10);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] o, input int zmode, output int lat);
        int  ms;
        bit  done;
        load_seq(o);
        ms = 0; lat = 0; done = 0;
        cnt_rw = 0; cnt_mw = 0; cnt_ill = 0; cnt_pcen = 0; cnt_jsrc = 0;
        for (int c = 0; c < 16 && !done; c++) begin
            one_cycle(ms, o, zmode);
            if (seq_q.size() > 0) ms = seq_q.pop_front();
            else                  ms = 0;
            if (bus.state == 4'd0) begin
                lat  = c + 1;
                done = 1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL fetch_timeout: opcode 0x%0h never returned to FETCH within 16 cycles", o);
        end
    endtask

    vec_t tbl[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, el, sum_lat, sum_mw, sum_rw, sum_js;
        logic [5:0] o;

        tbl[0] = '{6'h23, 0, 5, 1, 0, 0, 1, 0};
        tbl[1] = '{6'h2B, 1, 4, 0, 1, 0, 1, 0};
        tbl[2] = '{6'h00, 1, 4, 1, 0, 0, 1, 0};
        tbl[3] = '{6'h04, 1, 3, 0, 0, 0, 2, 0};
        tbl[4] = '{6'h04, 0, 3, 0, 0, 0, 1, 0};
        tbl[5] = '{6'h02, 0, 3, 0, 0, 0, 2, 1};
        tbl[6] = '{6'h3F, 1, 2, 0, 0, 1, 1, 0};
`ifdef MC_CTRL_ADDI_EN
        tbl[7] = '{6'h08, 0, 4, 1, 0, 0, 1, 0};
`else
        tbl[7] = '{6'h08, 0, 2, 0, 0, 1, 1, 0};
`endif
        tbl[8] = '{6'h01, 0, 2, 0, 0, 1, 1, 0};

        rst = 1'b1;
        bus.opcode = 6'h23;
        bus.zero   = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) one_cycle(0, 6'h23, 2);
        rst = 1'b0;

        // LW straight out of reset: first rst=0 cycle must already fetch.
        run_instr(6'h23, 0, lat);
        chk("lw_after_reset_lat", lat, 5);
        chk("lw_after_reset_rw", cnt_rw, 1);
        chk("lw_after_reset_pcen", cnt_pcen, 1);

        foreach (tbl[i]) begin
            run_instr(tbl[i].opc, tbl[i].z, lat);
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("vec%0d_rw", i), cnt_rw, tbl[i].rw);
            chk($sformatf("vec%0d_mw", i), cnt_mw, tbl[i].mw);
            chk($sformatf("vec%0d_ill", i), cnt_ill, tbl[i].ill);
            chk($sformatf("vec%0d_pcen", i), cnt_pcen, tbl[i].pcen);
            chk($sformatf("vec%0d_jsrc", i), cnt_jsrc, tbl[i].jsrc);
        end

        // Reset asserted while LW sits in MEMRD: outputs zero, then FETCH, never MEMWB.
        one_cycle(0, 6'h23, 0);
        one_cycle(1, 6'h23, 0);
        one_cycle(2, 6'h23, 0);
        rst = 1'b1;
        one_cycle(3, 6'h23, 0);
        rst = 1'b0;
        run_instr(6'h23, 0, lat);
        chk("lw_after_midreset_lat", lat, 5);

        // SW, RTYPE, J back to back.
        sum_lat = 0; sum_mw = 0; sum_rw = 0; sum_js = 0;
        run_instr(6'h2B, 2, lat);
        sum_lat += lat; sum_mw += cnt_mw; sum_rw += cnt_rw; sum_js += cnt_jsrc;
        run_instr(6'h00, 2, lat);
        sum_lat += lat; sum_mw += cnt_mw; sum_rw += cnt_rw; sum_js += cnt_jsrc;
        run_instr(6'h02, 2, lat);
        sum_lat += lat; sum_mw += cnt_mw; sum_rw += cnt_rw; sum_js += cnt_jsrc;
        chk("seq_lat", sum_lat, 11);
        chk("seq_mem_write", sum_mw, 1);
        chk("seq_reg_write", sum_rw, 1);
        chk("seq_jump_src", sum_js, 1);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0: o = 6'h00;
                1: o = 6'h23;
                2: o = 6'h2B;
                3: o = 6'h04;
                4: o = 6'h02;
                5: o = 6'h08;
                default: o = 6'($urandom);
            endcase
            load_seq(o);
            el = seq_q.size() + 1;
            run_instr(o, 2, lat);
            chk($sformatf("rand_lat_op%0h", o), lat, el);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OP_RTYPE, default 6'h00, R-type opcode.
REQ-002 Parameter OP_LW, default 6'h23, load-word opcode.
REQ-003 Parameter OP_SW, default 6'h2B, store-word opcode.
REQ-004 Parameter OP_BEQ, default 6'h04, branch-if-equal opcode.
REQ-005 Parameter OP_J, default 6'h02, jump opcode.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 opcode  input  6  instruction[31:26] from instruction register.
REQ-009 zero  input  1  ALU zero flag.
REQ-010 pc_en  output  1  PC load enable (pc_write OR (pc_write_cond AND zero)).
REQ-011 iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a  output  1 each  datapath controls.
REQ-012 alu_src_b, alu_op, pc_source  output  2 each  datapath mux selects / ALU class.
REQ-013 state  output  4  current FSM state code, for debug.
REQ-014 illegal_op  output  1  one-cycle pulse on unsupported opcode.

Function
REQ-015 Moore FSM; controls decoded from state register only, except pc_en, which also uses zero.
REQ-016 State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9.
REQ-017 FETCH: mem_read=1, ir_write=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, pc_write=1; next DECODE.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state: LW/SW->MEMADR; RTYPE->EXEC; BEQ->BRANCH; J->JUMP; any other opcode->FETCH with illegal_op=1.
REQ-019 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: LW->MEMRD; SW->MEMWR.
REQ-020 MEMRD: mem_read=1, iord=1; next MEMWB. MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-021 MEMWR: mem_write=1, iord=1; next FETCH.
REQ-022 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next ALUWB. ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1; next FETCH.
REQ-024 JUMP: pc_source=10, pc_write=1; next FETCH.
REQ-025 Every output not listed for a state SHALL be 0.
REQ-026 Instruction latency, FETCH to the next FETCH: LW 5, SW 4, RTYPE 4, BEQ 3, J 3, illegal 2 cycles.
REQ-027 Unused state codes (10-15, or 12-15 with the Configuration macro defined) SHALL go to FETCH on the next edge; all outputs are 0 while in them.
REQ-028 opcode is sampled only in DECODE, MEMADR and the ADDI path; it is a don't-care elsewhere.

Reset
REQ-029 rst=1 at a rising edge SHALL load FETCH, overriding any transition, including mid-instruction.
REQ-030 While rst=1, all control outputs and illegal_op SHALL be 0 combinationally; state reads 0.
REQ-031 The first fetch (pc_en=1) SHALL occur in the first cycle with rst=0.

Configuration
REQ-032 Macro MC_CTRL_ADDI_EN defined: opcode 6'h08 (ADDI) in DECODE->ADDIEXEC=10 (alu_src_a=1, alu_src_b=10, alu_op=00)->ADDIWB=11 (reg_write=1, reg_dst=0, mem_to_reg=0)->FETCH; latency 4.
REQ-033 Macro undefined: 6'h08 is illegal per REQ-018, and states 10/11 do not exist.

Verification
REQ-034 rst high 3 cycles, then low, opcode=6'h23 -> states 0,1,2,3,4,0; reg_write=1 only in state 4; pc_en=1 only in state 0.
REQ-035 opcode=6'h04, zero=1 in BRANCH -> pc_en=1, pc_source=01; repeat with zero=0 -> pc_en=0; both return to FETCH after 3 cycles.
REQ-036 opcode=6'h3F -> DECODE then FETCH, illegal_op=1 for exactly the DECODE cycle; no reg_write or mem_write is asserted.
REQ-037 LW in flight, rst=1 asserted during MEMRD -> FETCH on the next edge; outputs 0 while rst=1; mem_read is never asserted in the MEMWB cycle.
REQ-038 opcode=6'h08 -> with MC_CTRL_ADDI_EN: states 0,1,10,11,0, reg_write in state 11; without the macro: illegal_op pulse, then FETCH.
REQ-039 Sequence SW, RTYPE, J -> 4+4+3 cycles; mem_write exactly once; reg_write exactly once; pc_source=10 only in JUMP.
